// File: rtl/seq_alu_if.sv
// Request/response bundle for the registered multicycle ALU.
// The master issues ops; the slave (the ALU) returns registered results.
interface seq_alu_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             valid_in;
    logic             ready_in;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             valid_out;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             sign;
    logic             div_by_zero;

    modport master (
        output valid_in, alucontrol, a, b, shamt,
        input  ready_in, valid_out, result, hi, zero, sign, div_by_zero
    );

    modport slave (
        input  valid_in, alucontrol, a, b, shamt,
        output ready_in, valid_out, result, hi, zero, sign, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU for the multicycle MIPS datapath.
// Single-cycle ops complete next cycle; MULTU/DIVU iterate one bit per cycle.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic        clk,
    input  logic        reset,
    seq_alu_if.slave    bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_ZFR  = 4'b0100;
    localparam logic [3:0] OP_LI   = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t            state;
    logic [SHW-1:0]    count;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  mq;
    logic [WIDTH-1:0]  opb;
    logic [WIDTH-1:0]  res;
    logic [WIDTH-1:0]  hi_q;
    logic              dbz;
    logic              vout;

    logic [WIDTH-1:0]  op_res;
    logic signed [WIDTH-1:0] sra_res;
    logic [SHW:0]      zfr_amt;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_acc;
    logic [WIDTH-1:0]  mul_mq;
    logic [WIDTH:0]    div_sh;
    logic [WIDTH:0]    div_diff;
    logic [WIDTH-1:0]  div_rem;
    logic [WIDTH-1:0]  div_quo;
    logic              last;

    assign bus.ready_in    = (state == IDLE);
    assign bus.valid_out   = vout;
    assign bus.result      = res;
    assign bus.hi          = hi_q;
    assign bus.div_by_zero = dbz;
    assign bus.zero        = (res == '0);
    assign bus.sign        = res[WIDTH-1];

    // count runs 0..WIDTH-1; all ones marks the final iteration
    assign last = &count;

    // single-cycle op results from the live operands
    always_comb begin
        op_res  = '0;
        sra_res = $signed(bus.b) >>> bus.shamt;
        zfr_amt = {1'b0, bus.b[SHW-1:0]} + (SHW+1)'(1);
        case (bus.alucontrol)
            OP_AND: op_res = bus.a & bus.b;
            OP_OR:  op_res = bus.a | bus.b;
            OP_ADD: op_res = bus.a + bus.b;
            OP_SUB: op_res = bus.a - bus.b;
            OP_SLT: op_res = {{(WIDTH-1){1'b0}},
                              $signed(bus.a) < $signed(bus.b)};
            OP_SLL: op_res = bus.b << bus.shamt;
            OP_SRL: op_res = bus.b >> bus.shamt;
            OP_SRA: op_res = sra_res;
            OP_LI:  op_res = {{(WIDTH-16){1'b0}}, bus.b[15:0]};
            OP_ZFR: op_res = bus.a & ({WIDTH{1'b1}} << zfr_amt);
            default: op_res = '0;
        endcase
    end

    // one shift-add step and one restoring-divide step on the working regs
    always_comb begin
        mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
        mul_acc  = mul_sum[WIDTH:1];
        mul_mq   = {mul_sum[0], mq[WIDTH-1:1]};
        div_sh   = {acc, mq[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb};
        if (!div_diff[WIDTH]) begin
            div_rem = div_diff[WIDTH-1:0];
            div_quo = {mq[WIDTH-2:0], 1'b1};
        end else begin
            div_rem = div_sh[WIDTH-1:0];
            div_quo = {mq[WIDTH-2:0], 1'b0};
        end
    end

    // op acceptance, iteration and registered completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            mq    <= '0;
            opb   <= '0;
            res   <= '0;
            hi_q  <= '0;
            dbz   <= 1'b0;
            vout  <= 1'b0;
        end else begin
            vout <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        if (bus.alucontrol == OP_MULU) begin
                            state <= MUL;
                            count <= '0;
                            acc   <= '0;
                            mq    <= bus.a;
                            opb   <= bus.b;
                        end else if (bus.alucontrol == OP_DIVU &&
                                     bus.b != '0) begin
                            state <= DIV;
                            count <= '0;
                            acc   <= '0;
                            mq    <= bus.a;
                            opb   <= bus.b;
                        end else if (bus.alucontrol == OP_DIVU) begin
                            res  <= '1;
                            hi_q <= bus.a;
                            dbz  <= 1'b1;
                            vout <= 1'b1;
                        end else begin
                            res  <= op_res;
                            hi_q <= '0;
                            dbz  <= 1'b0;
                            vout <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_acc;
                    mq    <= mul_mq;
                    count <= count + 1'b1;
                    if (last) begin
                        state <= IDLE;
                        res   <= mul_mq;
                        hi_q  <= mul_acc;
                        dbz   <= 1'b0;
                        vout  <= 1'b1;
                    end
                end
                DIV: begin
                    acc   <= div_rem;
                    mq    <= div_quo;
                    count <= count + 1'b1;
                    if (last) begin
                        state <= IDLE;
                        res   <= div_quo;
                        hi_q  <= div_rem;
                        dbz   <= 1'b0;
                        vout  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
